// File: rtl/multicycle_main_ctrl.sv
// Multi-cycle main control FSM: fetch handshake, IF/ID/EX/(MEM)/WB sequencing and ALUOp generation.
// Defining CTRL_LOAD_STORE_EN adds lw/sw decode and the MEM state with the data-memory handshake.
module multicycle_main_ctrl #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned ALUOP_W  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               imem_ready_i,
  input  logic [31:0]        instr_i,
  input  logic               zero_i,
  input  logic               dmem_ready_i,
  output logic               imem_req_o,
  output logic               IRWrite_o,
  output logic               PCWrite_o,
  output logic               PCSrc_o,
  output logic [ALUOP_W-1:0] ALUOp_o,
  output logic               ALUSrc_o,
  output logic               RegDst_o,
  output logic               RegWrite_o,
  output logic               MemtoReg_o,
  output logic               dmem_req_o,
  output logic               dmem_we_o,
  output logic               fault_o,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    StIf  = 3'd0,
    StId  = 3'd1,
    StEx  = 3'd2,
    StMem = 3'd3,
    StWb  = 3'd4
  } state_e;

  localparam logic [5:0] OpR     = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSltiu = 6'b001011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpBne   = 6'b000101;
`ifdef CTRL_LOAD_STORE_EN
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
`endif

  localparam logic [ALUOP_W-1:0] AluR     = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AluAddi  = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AluSltiu = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AluBeq   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] AluLui   = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] AluOri   = ALUOP_W'(5);
  localparam logic [ALUOP_W-1:0] AluBne   = ALUOP_W'(6);

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  state_e      r_state, w_state_next;
  logic [5:0]  r_opcode, w_opcode_next;
  logic [7:0]  r_wait_cnt, w_wait_cnt_next;
  // Suppresses the fetch request for one cycle after reset release and after a timeout.
  logic        r_req_hold, w_req_hold_next;
  logic        w_timeout;

  logic               w_known, w_imm, w_branch, w_bne, w_rtype, w_load, w_store;
  logic [ALUOP_W-1:0] w_aluop;
  logic               w_unused_instr;

  assign w_unused_instr = ^instr_i[25:0];

  always_comb begin
    w_known  = 1'b1;
    w_aluop  = AluR;
    w_imm    = 1'b0;
    w_branch = 1'b0;
    w_bne    = 1'b0;
    w_rtype  = 1'b0;
    w_load   = 1'b0;
    w_store  = 1'b0;
    case (r_opcode)
      OpR:     w_rtype = 1'b1;
      OpAddi:  begin w_aluop = AluAddi;  w_imm = 1'b1; end
      OpSltiu: begin w_aluop = AluSltiu; w_imm = 1'b1; end
      OpLui:   begin w_aluop = AluLui;   w_imm = 1'b1; end
      OpOri:   begin w_aluop = AluOri;   w_imm = 1'b1; end
      OpBeq:   begin w_aluop = AluBeq;   w_branch = 1'b1; end
      OpBne:   begin w_aluop = AluBne;   w_branch = 1'b1; w_bne = 1'b1; end
`ifdef CTRL_LOAD_STORE_EN
      OpLw:    begin w_aluop = AluAddi;  w_imm = 1'b1; w_load = 1'b1; end
      OpSw:    begin w_aluop = AluAddi;  w_imm = 1'b1; w_store = 1'b1; end
`endif
      default: w_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= StIf;
      r_opcode   <= 6'd0;
      r_wait_cnt <= 8'd0;
      r_req_hold <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_opcode   <= w_opcode_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_req_hold <= w_req_hold_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_opcode_next   = r_opcode;
    w_wait_cnt_next = 8'd0;
    w_req_hold_next = 1'b0;
    w_timeout       = 1'b0;
    case (r_state)
      StIf: begin
        if (!r_req_hold) begin
          if (imem_ready_i) begin
            w_opcode_next = instr_i[31:26];
            w_state_next  = StId;
          end else if (r_wait_cnt == MaxWait) begin
            w_timeout       = 1'b1;
            w_req_hold_next = 1'b1;
          end else begin
            w_wait_cnt_next = r_wait_cnt + 8'd1;
          end
        end
      end
      StId:  w_state_next = w_known ? StEx : StIf;
      StEx: begin
        if (w_load || w_store) w_state_next = StMem;
        else if (w_branch)     w_state_next = StIf;
        else                   w_state_next = StWb;
      end
      StMem: begin
        if (dmem_ready_i) begin
          w_state_next = w_load ? StWb : StIf;
        end else if (r_wait_cnt == MaxWait) begin
          w_timeout       = 1'b1;
          w_req_hold_next = 1'b1;
          w_state_next    = StIf;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 8'd1;
        end
      end
      StWb:    w_state_next = StIf;
      default: w_state_next = StIf;
    endcase
  end

  always_comb begin
    imem_req_o = 1'b0;
    IRWrite_o  = 1'b0;
    PCWrite_o  = 1'b0;
    PCSrc_o    = 1'b0;
    ALUOp_o    = AluR;
    ALUSrc_o   = 1'b0;
    RegDst_o   = 1'b0;
    RegWrite_o = 1'b0;
    MemtoReg_o = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    fault_o    = w_timeout;
    state_o    = r_state;
    case (r_state)
      StIf: begin
        imem_req_o = !r_req_hold;
        IRWrite_o  = !r_req_hold && imem_ready_i;
        PCWrite_o  = !r_req_hold && imem_ready_i;
      end
      StId: fault_o = !w_known;
      StEx: begin
        ALUOp_o  = w_aluop;
        ALUSrc_o = w_imm;
        if (w_branch) begin
          PCSrc_o   = 1'b1;
          PCWrite_o = w_bne ? !zero_i : zero_i;
        end
      end
      StMem: begin
`ifdef CTRL_LOAD_STORE_EN
        dmem_req_o = 1'b1;
        dmem_we_o  = w_store;
`endif
      end
      StWb: begin
        ALUOp_o    = w_aluop;
        RegWrite_o = 1'b1;
        RegDst_o   = w_rtype;
        MemtoReg_o = w_load;
      end
      default: fault_o = 1'b1;
    endcase
  end

endmodule

// File: doc/multicycle_main_ctrl.md
Name: multicycle_main_ctrl

Overview:
- Multi-cycle main control FSM for the MIPS-subset CPU.
- Fetches each instruction through a req/ready handshake with instruction memory and latches the opcode.
- Sequences IF/ID/EX/WB and drives the datapath enables.
- Produces the 4-bit ALUOp code consumed by the ALU control block. This block is the producer side of that interface.

Parameters:
- MAX_WAIT, 15: maximum cycles held in a memory-wait state before abort; legal range 1..255.
- ALUOP_W, 4: width of the ALUOp code; fixed at 4 by the ALU control interface.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge
- rst_i  in  1  asynchronous reset, active-low
- imem_ready_i  in  1  instruction memory has data on instr_i this cycle
- instr_i  in  32  fetched instruction; sampled only when imem_req_o and imem_ready_i are both high
- zero_i  in  1  ALU zero flag, valid in EX
- imem_req_o  out  1  instruction fetch request
- IRWrite_o  out  1  latch instr_i into the datapath instruction register
- PCWrite_o  out  1  PC update enable
- PCSrc_o  out  1  0 selects PC+4, 1 selects the branch target
- ALUOp_o  out  4  0 R_TYPE, 1 ADDI, 2 SLTIU, 3 BEQ, 4 LUI, 5 ORI, 6 BNE
- ALUSrc_o  out  1  0 selects rt, 1 selects the immediate
- RegDst_o  out  1  0 selects rt, 1 selects rd
- RegWrite_o  out  1  register file write enable
- MemtoReg_o  out  1  write-back select: 1 selects memory data
- dmem_req_o  out  1  data memory request (feature only, else 0)
- dmem_we_o  out  1  data memory write (feature only, else 0)
- dmem_ready_i  in  1  data memory ready (feature only, else ignored)
- fault_o  out  1  one-cycle pulse on illegal opcode or wait timeout
- state_o  out  3  encoded FSM state for debug

Behaviour:
- Reset (rst_i low, asynchronous): state=IF, opcode register=0, wait counter=0.
  - All outputs 0 except state_o=IF.
  - imem_req_o rises on the first edge after reset release.
- States and encodings: IF=0, ID=1, EX=2, MEM=3, WB=4. Codes 5-7 are illegal and go to IF with a fault_o pulse.
- IF:
  - imem_req_o=1.
  - On imem_ready_i=1: IRWrite_o=1, PCWrite_o=1, PCSrc_o=0; latch instr_i[31:26]; go to ID.
  - Otherwise stay in IF and increment the wait counter.
- ID:
  - Decode the latched opcode: 000000 R, 001000 addi, 001011 sltiu, 000100 beq, 001111 lui, 001101 ori, 000101 bne.
  - Unknown opcode: fault_o pulse, go to IF, no write enables asserted.
  - Known opcode: go to EX.
- EX:
  - ALUOp_o is the code for the opcode.
  - ALUSrc_o=1 for addi, sltiu, lui, ori. ALUSrc_o=0 for R, beq, bne.
  - beq: PCWrite_o=zero_i, PCSrc_o=1, then go to IF.
  - bne: PCWrite_o=~zero_i, PCSrc_o=1, then go to IF.
  - All other opcodes go to WB.
- WB:
  - RegWrite_o=1 for exactly one cycle.
  - RegDst_o=1 for R-type, 0 otherwise. MemtoReg_o=0.
  - ALUOp_o keeps the EX value.
  - Go to IF.
- ALUOp_o outside EX/WB: 0.
- Minimum latency, counted from the imem_ready_i cycle: R-type and immediate ops 4 cycles, branches 3 cycles.
- Wait counter:
  - Cleared on every state change.
  - Saturates at MAX_WAIT.
  - When it reaches MAX_WAIT in a wait state with ready still low: fault_o pulse, drop the request for 1 cycle, restart IF. PC is not written.
- Handshake:
  - The request stays high until ready is sampled.
  - A ready arriving when no request is high is ignored.
  - A ready arriving in the same cycle as the timeout is taken as ready; no fault.
- Reset asserted mid-instruction: immediate return to IF. No partial write enables may leak in the reset cycle.
- Control outputs are registered-state decoded, i.e. Moore outputs. Exceptions that combine the current state with a live input:
  - IRWrite_o and PCWrite_o in IF, gated by imem_ready_i.
  - PCWrite_o in EX, gated by zero_i.

Optional Feature:
- Macro: CTRL_LOAD_STORE_EN.
- With the macro defined:
  - lw (100011) and sw (101011) are decoded.
  - In EX: ALUOp_o=ADDI, ALUSrc_o=1.
  - Next state is MEM. In MEM: dmem_req_o=1; dmem_we_o=1 for sw.
  - MEM waits for dmem_ready_i, with the same MAX_WAIT timeout rule.
  - After MEM, lw goes to WB with MemtoReg_o=1, RegDst_o=0. sw goes to IF.
- Without the macro:
  - lw and sw are illegal opcodes.
  - The MEM state is never entered.
  - dmem_req_o and dmem_we_o are tied to 0.

Test Plan:
- Reset with rst_i low mid-EX of addi -> all outputs 0 immediately; state_o=0; imem_req_o=1 the cycle after release.
- addu (op 000000), imem_ready_i high in the first IF cycle -> ALUOp_o=0 in EX; RegWrite_o=1, RegDst_o=1 exactly 3 cycles after the fetch cycle.
- beq with zero_i=1, then bne with zero_i=1 -> beq: PCWrite_o=1, PCSrc_o=1 in EX. bne: PCWrite_o=0. Both: no RegWrite_o; IF follows.
- ori, with imem_ready_i delayed 5 cycles -> imem_req_o held 6 cycles; in EX ALUOp_o=5, ALUSrc_o=1; no fault.
- Opcode 111111 -> fault_o 1-cycle pulse in ID; no RegWrite_o or branch PC write; next state IF.
- imem_ready_i never rises, MAX_WAIT=15 -> fault_o pulses after 15 wait cycles; imem_req_o low 1 cycle, then reasserts.
